// File: rtl/saber_color_fader.sv
// saber_color_fader: valid/ready colour sequencer that jumps or ramps R/G/B toward a target at a fixed step rate
module saber_color_fader #(
  parameter int STEP_DIV = 4,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_r,
  input  logic [7:0] cmd_g,
  input  logic [7:0] cmd_b,
  input  logic       cmd_instant,
  input  logic       abort,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       busy,
  output logic       done
);
  typedef enum logic {IDLE, FADE} state_t;
  localparam logic [15:0] LAST  = 16'(STEP_DIV - 1);
  localparam logic [8:0]  STEP9 = 9'(STEP);
  state_t      state;
  logic [15:0] div;
  logic [7:0]  tgt_r, tgt_g, tgt_b;
  logic [7:0]  nxt_r, nxt_g, nxt_b;
  logic        same, arrive;
  // 9-bit distance clamps the increment so a step lands exactly on the target
  function automatic logic [7:0] step_ch(input logic [7:0] c, input logic [7:0] t);
    logic [8:0] d, s, n;
    d = (c < t) ? {1'b0, t} - {1'b0, c} : {1'b0, c} - {1'b0, t};
    s = (d < STEP9) ? d : STEP9;
    n = (c < t) ? {1'b0, c} + s : {1'b0, c} - s;
    return n[7:0];
  endfunction
  always_comb begin
    nxt_r  = step_ch(r_out, tgt_r);
    nxt_g  = step_ch(g_out, tgt_g);
    nxt_b  = step_ch(b_out, tgt_b);
    same   = {cmd_r, cmd_g, cmd_b} == {r_out, g_out, b_out};
    arrive = {nxt_r, nxt_g, nxt_b} == {tgt_r, tgt_g, tgt_b};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      div       <= '0;
      {r_out, g_out, b_out} <= '0;
      {tgt_r, tgt_g, tgt_b} <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          {tgt_r, tgt_g, tgt_b} <= {cmd_r, cmd_g, cmd_b};
          if (cmd_instant || same) begin
            {r_out, g_out, b_out} <= {cmd_r, cmd_g, cmd_b};
            done <= 1'b1;
          end else begin
            div       <= '0;
            state     <= FADE;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
      end else if (abort) begin
        state     <= IDLE;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
      end else if (div == LAST) begin
        div <= '0;
        {r_out, g_out, b_out} <= {nxt_r, nxt_g, nxt_b};
        if (arrive) begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
      end else begin
        div <= div + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_saber_color_fader.sv
// tb_saber_color_fader: directed checks of reset, instant load, fades up/down, abort and mid-fade reset
module tb_saber_color_fader;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v0 = 1'b0, i0 = 1'b0, a0 = 1'b0, rdy0, busy0, done0;
  logic [7:0] r0 = '0, g0 = '0, b0 = '0, ro0, go0, bo0;
  logic v1 = 1'b0, i1 = 1'b0, a1 = 1'b0, rdy1, busy1, done1;
  logic [7:0] r1 = '0, g1 = '0, b1 = '0, ro1, go1, bo1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  saber_color_fader u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_r(r0), .cmd_g(g0), .cmd_b(b0), .cmd_instant(i0), .abort(a0),
    .r_out(ro0), .g_out(go0), .b_out(bo0), .busy(busy0), .done(done0)
  );

  saber_color_fader #(.STEP_DIV(1), .STEP(4)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_r(r1), .cmd_g(g1), .cmd_b(b1), .cmd_instant(i1), .abort(a1),
    .r_out(ro1), .g_out(go1), .b_out(bo1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmd0(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic inst);
    {r0, g0, b0, i0} = {r, g, b, inst};
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_r", ro0, 0); chk("rst_g", go0, 0); chk("rst_b", bo0, 0);
    chk("rst_ready", rdy0, 1); chk("rst_busy", busy0, 0); chk("rst_done", done0, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_done", done0, 0);

    cmd0(8'd255, 8'd128, 8'd0, 1'b1);
    chk("inst_r", ro0, 255); chk("inst_g", go0, 128); chk("inst_b", bo0, 0);
    chk("inst_done", done0, 1); chk("inst_busy", busy0, 0);
    tick();
    chk("inst_done_clr", done0, 0); chk("inst_busy2", busy0, 0);

    cmd0(8'd0, 8'd0, 8'd0, 1'b1);
    tick();
    cmd0(8'd3, 8'd10, 8'd0, 1'b0);
    chk("fade_busy0", busy0, 1); chk("fade_ready0", rdy0, 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("fade_r", ro0, (k / 4 > 3) ? 3 : k / 4);
      chk("fade_g", go0, k / 4);
      chk("fade_b", bo0, 0);
      chk("fade_busy", busy0, (k < 40) ? 1 : 0);
      chk("fade_ready", rdy0, (k < 40) ? 0 : 1);
      chk("fade_done", done0, (k == 40) ? 1 : 0);
    end
    tick();
    chk("fade_done_clr", done0, 0);

    cmd0(8'd5, 8'd0, 8'd0, 1'b1);
    tick();
    cmd0(8'd10, 8'd0, 8'd0, 1'b0);
    tick(); tick(); tick();
    chk("ab_pre_busy", busy0, 1);
    a0 = 1'b1;
    tick();
    a0 = 1'b0;
    chk("ab_r", ro0, 5); chk("ab_done", done0, 0);
    chk("ab_ready", rdy0, 1); chk("ab_busy", busy0, 0);
    cmd0(8'd1, 8'd2, 8'd3, 1'b1);
    chk("ab_new_r", ro0, 1); chk("ab_new_g", go0, 2); chk("ab_new_b", bo0, 3);
    chk("ab_new_done", done0, 1);
    tick();

    {r0, g0, b0, i0} = {8'd100, 8'd0, 8'd0, 1'b0};
    v0 = 1'b1;
    tick();
    {r0, g0, b0, i0} = {8'd0, 8'd0, 8'd0, 1'b0};
    tick(); tick(); tick(); tick(); tick();
    chk("mr_busy", busy0, 1); chk("mr_ready", rdy0, 0);
    chk("mr_r", ro0, 2); chk("mr_g", go0, 1); chk("mr_b", bo0, 2);
    rst_n = 1'b0;
    tick();
    chk("mr_rst_r", ro0, 0); chk("mr_rst_g", go0, 0); chk("mr_rst_b", bo0, 0);
    chk("mr_rst_busy", busy0, 0); chk("mr_rst_done", done0, 0); chk("mr_rst_ready", rdy0, 1);
    rst_n = 1'b1;
    tick();
    v0 = 1'b0;
    chk("mr_zero_done", done0, 1); chk("mr_zero_busy", busy0, 0); chk("mr_zero_r", ro0, 0);
    tick();
    chk("mr_zero_done_clr", done0, 0);

    {r1, g1, b1, i1} = {8'd255, 8'd255, 8'd255, 1'b1};
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("dn_init_g", go1, 255); chk("dn_init_done", done1, 1);
    tick();
    {r1, g1, b1, i1} = {8'd250, 8'd0, 8'd255, 1'b0};
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("dn_busy0", busy1, 1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("dn_r", ro1, (k == 1) ? 251 : 250);
      chk("dn_g", go1, (k < 64) ? 255 - 4 * k : 0);
      chk("dn_b", bo1, 255);
      chk("dn_done", done1, (k == 64) ? 1 : 0);
      chk("dn_busy", busy1, (k < 64) ? 1 : 0);
    end
    tick();
    chk("dn_done_clr", done1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
